// File: rtl/te_pkg.sv
// Shared types and constants for the transmission-estimation window controller.
package te_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } te_state_e;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MEAN   = 2'b01;
  localparam logic [1:0] MODE_CENTER = 2'b10;

  // Weight bit order is {corner, edge, center}.
  localparam logic [2:0] WEIGHTS_MEAN   = 3'b000;
  localparam logic [2:0] WEIGHTS_CENTER = 3'b111;

endpackage

// File: rtl/te_pos_counter.sv
// Raster row/column position counter with advance, wrap and first/last flags.
module te_pos_counter
  import te_pkg::*;
#(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 8,
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_adv,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_wrap_c,
  output logic             o_first_row_c,
  output logic             o_last_row_c,
  output logic             o_first_col_c,
  output logic             o_last_col_c
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  assign o_row         = r_row;
  assign o_col         = r_col;
  assign o_first_row_c = (r_row == '0);
  assign o_last_row_c  = (r_row == ROW_W'(ROWS - 1));
  assign o_first_col_c = (r_col == '0);
  assign o_last_col_c  = (r_col == COL_W'(COLS - 1));
  assign o_wrap_c      = i_adv && o_last_col_c;

  // Column wraps at the row end; row wraps at the frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (o_last_col_c) begin
        r_col <= '0;
        r_row <= o_last_row_c ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/te_window_ctrl.sv
// Frame sequencer for the 3x3 transmission-estimation window filter.
// Edge-adaptive weighting is built only when TE_WF_EDGE_ADAPT_EN is defined.
module te_window_ctrl
  import te_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [1:0] i_cfg_mode,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic       i_edge_flag,
  output logic       o_win_shift,
  output logic       o_pad_top,
  output logic       o_pad_bot,
  output logic       o_pad_left,
  output logic       o_pad_right,
  output logic       o_w_corner,
  output logic       o_w_edge,
  output logic       o_w_center,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  te_state_e r_state;
  te_state_e w_state_nxt;

  logic       r_out_valid;
  logic       r_out_last;
  logic [2:0] r_weights;
  logic [1:0] r_mode;
  logic       r_busy;
  logic       r_frame_done;

  logic       w_in_ready;
  logic       w_flush_step;
  logic       w_load;
  logic       w_in_hs;
  logic       w_out_free;
  logic       w_arm;
  logic       w_active;
  logic       w_border;
  logic [2:0] w_weights;
  logic       w_unused_sink;

  logic [ROW_W-1:0] w_in_row;
  logic [COL_W-1:0] w_in_col;
  logic             w_in_wrap, w_in_first_row, w_in_last_row, w_in_first_col, w_in_last_col;
  logic [ROW_W-1:0] w_out_row;
  logic [COL_W-1:0] w_out_col;
  logic             w_out_wrap, w_out_first_row, w_out_last_row, w_out_first_col, w_out_last_col;

  assign w_out_free = !r_out_valid || i_out_ready;
  assign w_arm      = (r_state == ST_IDLE) && i_start;
  assign w_active   = (r_state != ST_IDLE);
  assign w_in_hs    = i_in_valid && w_in_ready;

  te_pos_counter #(.COLS(IMG_WIDTH), .ROWS(IMG_HEIGHT)) u_in_pos (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_arm),
    .i_adv         (w_in_hs),
    .o_row         (w_in_row),
    .o_col         (w_in_col),
    .o_wrap_c      (w_in_wrap),
    .o_first_row_c (w_in_first_row),
    .o_last_row_c  (w_in_last_row),
    .o_first_col_c (w_in_first_col),
    .o_last_col_c  (w_in_last_col)
  );

  te_pos_counter #(.COLS(IMG_WIDTH), .ROWS(IMG_HEIGHT)) u_out_pos (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_arm),
    .i_adv         (w_load),
    .o_row         (w_out_row),
    .o_col         (w_out_col),
    .o_wrap_c      (w_out_wrap),
    .o_first_row_c (w_out_first_row),
    .o_last_row_c  (w_out_last_row),
    .o_first_col_c (w_out_first_col),
    .o_last_col_c  (w_out_last_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FILL ends on pixel index IMG_WIDTH (row 1, col 0); the last output step waits for its handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_flush_step = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        w_in_ready = 1'b1;
        if (i_in_valid && (w_in_row == ROW_W'(1)) && w_in_first_col) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_in_ready = w_out_free;
        w_load     = i_in_valid && w_out_free;
        if (w_load && w_in_last_row && w_in_last_col) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_flush_step = w_out_free && !(r_out_valid && r_out_last);
        w_load       = w_flush_step;
        if (r_out_valid && r_out_last && i_out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_border = w_out_first_row || w_out_last_row || w_out_first_col || w_out_last_col;

  // Border centres always take mean weights regardless of mode.
  always_comb begin
    w_weights = WEIGHTS_MEAN;
    if (!w_border) begin
      case (r_mode)
        MODE_CENTER: w_weights = WEIGHTS_CENTER;
`ifdef TE_WF_EDGE_ADAPT_EN
        MODE_AUTO:   w_weights = i_edge_flag ? WEIGHTS_CENTER : WEIGHTS_MEAN;
`endif
        default:     w_weights = WEIGHTS_MEAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_weights    <= WEIGHTS_MEAN;
      r_mode       <= MODE_AUTO;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_FLUSH) && r_out_valid && r_out_last && i_out_ready;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_arm) r_mode <= i_cfg_mode;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_last  <= w_out_last_row && w_out_last_col;
        r_weights   <= w_weights;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef TE_WF_EDGE_ADAPT_EN
  assign w_unused_sink = ^{w_in_col, w_in_wrap, w_in_first_row, w_out_row, w_out_col, w_out_wrap};
`else
  assign w_unused_sink = ^{w_in_col, w_in_wrap, w_in_first_row, w_out_row, w_out_col, w_out_wrap,
                           i_edge_flag};
`endif

  assign o_in_ready   = w_in_ready;
  assign o_win_shift  = w_in_hs || w_flush_step;
  assign o_pad_top    = w_active && w_out_first_row;
  assign o_pad_bot    = w_active && w_out_last_row;
  assign o_pad_left   = w_active && w_out_first_col;
  assign o_pad_right  = w_active && w_out_last_col;
  assign o_w_corner   = r_weights[2];
  assign o_w_edge     = r_weights[1];
  assign o_w_center   = r_weights[0];
  assign o_out_valid  = r_out_valid;
  assign o_out_last   = r_out_last;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_te_window_ctrl.sv
// Self-checking bench for te_window_ctrl: frame table plus scoreboard, with reset corner cases.
module tb_te_window_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int BUDGET = 400;

  typedef struct {
    logic [1:0] mode;
    int         edge_tgt;   // -1 none, -2 every centre, else centre index
    int         stall_at;
    int         stall_len;
    int         gap;
    bit         poke;
    int         exp_c;      // outputs expected with weights 111
  } frame_t;

  typedef struct {
    logic [2:0] w;
    logic       last;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start, i_in_valid, i_edge_flag, i_out_ready;
  logic [1:0] i_cfg_mode;
  logic o_in_ready, o_win_shift, o_pad_top, o_pad_bot, o_pad_left, o_pad_right;
  logic o_w_corner, o_w_edge, o_w_center, o_out_valid, o_out_last, o_busy, o_frame_done;

  te_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_cfg_mode   (i_cfg_mode),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_edge_flag  (i_edge_flag),
    .o_win_shift  (o_win_shift),
    .o_pad_top    (o_pad_top),
    .o_pad_bot    (o_pad_bot),
    .o_pad_left   (o_pad_left),
    .o_pad_right  (o_pad_right),
    .o_w_corner   (o_w_corner),
    .o_w_edge     (o_w_edge),
    .o_w_center   (o_w_center),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_last   (o_out_last),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, advanced at each falling edge.
  bit         mon_en = 1'b0;
  bit         m_active = 1'b0;
  bit         m_fd_pend = 1'b0;
  logic [1:0] m_mode = 2'b00;
  int         n_in = 0;
  int         n_loaded = 0;
  int         n_popped = 0;
  int         n_w111 = 0;
  item_t      q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_weights(input int idx, input logic [1:0] mode, input logic edge_in);
    int r, c;
    r = idx / W;
    c = idx % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 3'b000;
    if (mode == 2'b10) return 3'b111;
`ifdef TE_WF_EDGE_ADAPT_EN
    if (mode == 2'b00) return edge_in ? 3'b111 : 3'b000;
`endif
    return 3'b000;
  endfunction

  always @(negedge clk) begin
    bit    was_active, fill, run, flush, exp_ov, exp_ir, hs, step, produce;
    int    r, c;
    item_t it;
    if (mon_en) begin
      was_active = m_active;
      exp_ov = (q.size() > 0);
      chk("out_valid", o_out_valid, exp_ov);
      chk("busy", o_busy, m_active);
      chk("frame_done", o_frame_done, m_fd_pend);
      m_fd_pend = 1'b0;
      fill  = m_active && (n_in < W + 1);
      run   = m_active && (n_in >= W + 1) && (n_in < W * H);
      flush = m_active && (n_in == W * H);
      exp_ir = (fill || run) && (fill || !exp_ov || i_out_ready);
      chk("in_ready", o_in_ready, exp_ir);
      hs   = i_in_valid && exp_ir;
      step = flush && (n_loaded < W * H) && (!exp_ov || i_out_ready);
      chk("win_shift", o_win_shift, hs || step);
      produce = (run && hs) || step;
      if (!m_active) chk("pads_idle", {o_pad_top, o_pad_bot, o_pad_left, o_pad_right}, 0);
      if (exp_ov && i_out_ready) begin
        it = q.pop_front();
        chk("weights", {o_w_corner, o_w_edge, o_w_center}, it.w);
        chk("out_last", o_out_last, it.last);
        n_popped++;
        if ({o_w_corner, o_w_edge, o_w_center} == 3'b111) n_w111++;
        if (it.last) begin
          m_fd_pend = 1'b1;
          m_active  = 1'b0;
        end
      end
      if (produce) begin
        r = n_loaded / W;
        c = n_loaded % W;
        chk("pads", {o_pad_top, o_pad_bot, o_pad_left, o_pad_right},
            {28'd0, r == 0, r == H - 1, c == 0, c == W - 1});
        it.w    = exp_weights(n_loaded, m_mode, i_edge_flag);
        it.last = (n_loaded == W * H - 1);
        q.push_back(it);
        n_loaded++;
      end
      if (hs) n_in++;
      if (!was_active && i_start) begin
        m_active = 1'b1;
        m_mode   = i_cfg_mode;
        n_in     = 0;
        n_loaded = 0;
        n_popped = 0;
        n_w111   = 0;
        q.delete();
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk(name, {o_in_ready, o_win_shift, o_pad_top, o_pad_bot, o_pad_left, o_pad_right,
               o_w_corner, o_w_edge, o_w_center, o_out_valid, o_out_last, o_busy, o_frame_done}, 0);
  endtask

  task automatic pulse_start(input logic [1:0] mode);
    @(posedge clk); #1;
    i_cfg_mode = mode;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start    = 1'b0;
  endtask

  task automatic run_frame(input frame_t f);
    int cyc;
    pulse_start(f.mode);
    cyc = 0;
    while (m_active && cyc < BUDGET) begin
      i_in_valid  = !(f.gap != 0 && (cyc % f.gap) == f.gap - 1);
      i_out_ready = !(cyc >= f.stall_at && cyc < f.stall_at + f.stall_len);
      i_edge_flag = (f.mode == 2'b00) && (f.edge_tgt == -2 || n_loaded == f.edge_tgt);
      if (f.poke && cyc == 20) begin
        i_start    = 1'b1;
        i_cfg_mode = ~f.mode;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_start     = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    i_edge_flag = 1'b0;
    chk("frame_timeout", cyc < BUDGET, 1);
    chk("frame_outputs", n_popped, W * H);
    chk("frame_w111", n_w111, f.exp_c);
  endtask

  frame_t tbl[8];

  initial begin
    int cyc;
`ifdef TE_WF_EDGE_ADAPT_EN
    localparam int AUTO_ONE = 1;
    localparam int AUTO_ALL = (W - 2) * (H - 2);
`else
    localparam int AUTO_ONE = 0;
    localparam int AUTO_ALL = 0;
`endif
    tbl[0] = '{2'b01, -1,  0, 0, 0, 1'b0, 0};
    tbl[1] = '{2'b00, 11,  0, 0, 0, 1'b0, AUTO_ONE};
    tbl[2] = '{2'b00,  3,  0, 0, 0, 1'b0, 0};
    tbl[3] = '{2'b01, -1, 14, 5, 3, 1'b1, 0};
    tbl[4] = '{2'b10, -1,  0, 0, 0, 1'b0, (W - 2) * (H - 2)};
    tbl[5] = '{2'b11, -1,  0, 0, 0, 1'b0, 0};
    tbl[6] = '{2'b00, -2,  0, 0, 0, 1'b0, AUTO_ALL};
    tbl[7] = '{2'b10, -1, 20, 5, 2, 1'b0, (W - 2) * (H - 2)};

    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_cfg_mode  = 2'b00;
    i_in_valid  = 1'b0;
    i_edge_flag = 1'b0;
    i_out_ready = 1'b1;
    #12;
    check_all_zero("reset_outputs");
    #10;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    // Reset asserted while the final row is flushing under backpressure.
    pulse_start(2'b10);
    cyc = 0;
    i_in_valid = 1'b1;
    while (n_in < W * H && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("flush_reach", cyc < BUDGET, 1);
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all_zero("reset_mid_flush");
    @(posedge clk); #3;
    rst_n       = 1'b1;
    i_out_ready = 1'b1;
    i_in_valid  = 1'b0;
    m_active    = 1'b0;
    m_fd_pend   = 1'b0;
    q.delete();
    mon_en      = 1'b1;
    run_frame(tbl[0]);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
